mc_control_unit: RTL and testbench



---
 rtl/mc_control_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit: registered datapath controls decoded from the next state.
// Optional macro CU_BRANCH_JUMP_EN enables the branch, JAL and JALR states.
module mc_control_unit #(
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                zero,
    input  logic                alu_lt,
    input  logic                mem_ready,
    output logic [ALU_OP_W-1:0] ALU_OP,
    output logic                rs2_imm_s,
    output logic                alu_a_s,
    output logic [1:0]          w_data_s,
    output logic [1:0]          pc_s,
    output logic                Reg_Write,
    output logic                IR_Write,
    output logic                PC_Write,
    output logic                Mem_Write,
    output logic                Mem_Read,
    output logic [2:0]          mem_size,
    output logic                fault
);
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;

    typedef enum logic [4:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXR, S_EXI, S_WB, S_LUI, S_AUIPC, S_ADDR,
        S_MRD, S_MWB, S_MWR, S_BR, S_BRD, S_JAL, S_JALR, S_JALR2, S_TRAP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
    logic                rs2_imm_s_q, rs2_imm_s_d;
    logic                alu_a_s_q, alu_a_s_d;
    logic [1:0]          w_data_s_q, w_data_s_d;
    logic                reg_write_q, reg_write_d;
    logic                ir_write_q, ir_write_d;
    logic                pc_write_q, pc_write_d;
    logic                mem_write_q, mem_write_d;
    logic                mem_read_q, mem_read_d;
    logic [2:0]          mem_size_q, mem_size_d;
    logic                fault_q, fault_d;
`ifdef CU_BRANCH_JUMP_EN
    logic [1:0]          pc_s_q, pc_s_d;
    logic                br_taken;

    // Odd funct3 inverts the condition (bne, bge, bgeu).
    assign br_taken = funct3[2] ? (alu_lt ^ funct3[0]) : (zero ^ funct3[0]);
    assign pc_s     = pc_s_q;
`else
    assign pc_s     = 2'b00;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_op_d    = alu_op_q;
        rs2_imm_s_d = rs2_imm_s_q;
        alu_a_s_d   = alu_a_s_q;
        w_data_s_d  = w_data_s_q;
        mem_size_d  = mem_size_q;
        fault_d     = fault_q;
        reg_write_d = 1'b0;
        ir_write_d  = 1'b0;
        pc_write_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
`ifdef CU_BRANCH_JUMP_EN
        pc_s_d      = pc_s_q;
`endif

        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    7'b0110011: state_d = S_EXR;
                    7'b0010011: state_d = S_EXI;
                    7'b0110111: state_d = S_LUI;
                    7'b0010111: state_d = S_AUIPC;
                    7'b0000011: state_d = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                          ? S_ADDR : S_TRAP;
                    7'b0100011: state_d = (funct3 inside {3'b000, 3'b001, 3'b010}) ? S_ADDR : S_TRAP;
`ifdef CU_BRANCH_JUMP_EN
                    7'b1100011: state_d = S_BR;
                    7'b1101111: state_d = S_JAL;
                    7'b1100111: state_d = (funct3 == 3'b000) ? S_JALR : S_TRAP;
`endif
                    default:    state_d = S_TRAP;
                endcase
            end
            S_EXR, S_EXI, S_AUIPC: state_d = S_WB;
            S_WB, S_LUI, S_MWB:    state_d = S_FETCH;
            S_ADDR: begin
                state_d = opcode[5] ? S_MWR : S_MRD;
                cnt_d   = '0;
            end
            S_MRD, S_MWR: begin
                // A ready on the final allowed wait cycle still completes the access.
                if (mem_ready) begin
                    state_d = (state_q == S_MRD) ? S_MWB : S_FETCH;
                end else if (MEM_TIMEOUT > 0 && cnt_q == CNT_W'(MEM_TIMEOUT)) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef CU_BRANCH_JUMP_EN
            S_BR:    state_d = (funct3 inside {3'b010, 3'b011}) ? S_TRAP : S_BRD;
            S_BRD, S_JAL, S_JALR2: state_d = S_FETCH;
            S_JALR:  state_d = S_JALR2;
`endif
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        case (state_d)
            S_FETCH: begin
                pc_write_d = 1'b1;
                ir_write_d = 1'b1;
`ifdef CU_BRANCH_JUMP_EN
                pc_s_d     = 2'b00;
`endif
            end
            S_EXR: begin
                rs2_imm_s_d = 1'b0;
                alu_op_d    = ALU_OP_W'({funct7[5], funct3});
            end
            S_EXI: begin
                rs2_imm_s_d = 1'b1;
                alu_op_d    = ALU_OP_W'({(funct3 == 3'b101) & funct7[5], funct3});
            end
            S_WB: begin
                reg_write_d = 1'b1;
                w_data_s_d  = 2'b00;
            end
            S_LUI: begin
                reg_write_d = 1'b1;
                w_data_s_d  = 2'b01;
            end
            S_AUIPC: begin
                alu_a_s_d   = 1'b1;
                rs2_imm_s_d = 1'b1;
                alu_op_d    = ALU_OP_W'(OP_ADD);
            end
            S_ADDR: begin
                alu_a_s_d   = 1'b0;
                rs2_imm_s_d = 1'b1;
                alu_op_d    = ALU_OP_W'(OP_ADD);
                mem_size_d  = funct3;
            end
            S_MRD: mem_read_d  = 1'b1;
            S_MWR: mem_write_d = 1'b1;
            S_MWB: begin
                reg_write_d = 1'b1;
                w_data_s_d  = 2'b10;
            end
`ifdef CU_BRANCH_JUMP_EN
            S_BR: begin
                rs2_imm_s_d = 1'b0;
                if (funct3[2:1] == 2'b00)      alu_op_d = ALU_OP_W'(OP_SUB);
                else if (funct3[2:1] == 2'b10) alu_op_d = ALU_OP_W'(OP_SLT);
                else if (funct3[2:1] == 2'b11) alu_op_d = ALU_OP_W'(OP_SLTU);
            end
            S_BRD: begin
                if (br_taken) begin
                    pc_write_d = 1'b1;
                    pc_s_d     = 2'b01;
                end
            end
            S_JAL: begin
                reg_write_d = 1'b1;
                w_data_s_d  = 2'b11;
                pc_write_d  = 1'b1;
                pc_s_d      = 2'b01;
            end
            S_JALR: begin
                alu_op_d    = ALU_OP_W'(OP_ADD);
                rs2_imm_s_d = 1'b1;
            end
            S_JALR2: begin
                reg_write_d = 1'b1;
                w_data_s_d  = 2'b11;
                pc_write_d  = 1'b1;
                pc_s_d      = 2'b10;
            end
`endif
            S_TRAP:  fault_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            alu_op_q    <= '0;
            rs2_imm_s_q <= 1'b0;
            alu_a_s_q   <= 1'b0;
            w_data_s_q  <= 2'b00;
            reg_write_q <= 1'b0;
            ir_write_q  <= 1'b0;
            pc_write_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_size_q  <= 3'b000;
            fault_q     <= 1'b0;
`ifdef CU_BRANCH_JUMP_EN
            pc_s_q      <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_op_q    <= alu_op_d;
            rs2_imm_s_q <= rs2_imm_s_d;
            alu_a_s_q   <= alu_a_s_d;
            w_data_s_q  <= w_data_s_d;
            reg_write_q <= reg_write_d;
            ir_write_q  <= ir_write_d;
            pc_write_q  <= pc_write_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            mem_size_q  <= mem_size_d;
            fault_q     <= fault_d;
`ifdef CU_BRANCH_JUMP_EN
            pc_s_q      <= pc_s_d;
`endif
        end
    end

    assign ALU_OP    = alu_op_q;
    assign rs2_imm_s = rs2_imm_s_q;
    assign alu_a_s   = alu_a_s_q;
    assign w_data_s  = w_data_s_q;
    assign Reg_Write = reg_write_q;
    assign IR_Write  = ir_write_q;
    assign PC_Write  = pc_write_q;
    assign Mem_Write = mem_write_q;
    assign Mem_Read  = mem_read_q;
    assign mem_size  = mem_size_q;
    assign fault     = fault_q;
endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed cases then random instructions checked against
// a per-instruction expected-cycle trace built from the instruction-class rules.
module tb_mc_control_unit;
    localparam int TO  = 4;
    localparam int AOW = 6;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [6:0]     opcode = '0;
    logic [2:0]     funct3 = '0;
    logic [6:0]     funct7 = '0;
    logic           zero = 1'b0;
    logic           alu_lt = 1'b0;
    logic           mem_ready = 1'b0;
    logic [AOW-1:0] ALU_OP;
    logic           rs2_imm_s, alu_a_s;
    logic [1:0]     w_data_s, pc_s;
    logic           Reg_Write, IR_Write, PC_Write, Mem_Write, Mem_Read;
    logic [2:0]     mem_size;
    logic           fault;

    mc_control_unit #(.ALU_OP_W(AOW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .alu_lt(alu_lt), .mem_ready(mem_ready), .ALU_OP(ALU_OP),
        .rs2_imm_s(rs2_imm_s), .alu_a_s(alu_a_s), .w_data_s(w_data_s), .pc_s(pc_s),
        .Reg_Write(Reg_Write), .IR_Write(IR_Write), .PC_Write(PC_Write),
        .Mem_Write(Mem_Write), .Mem_Read(Mem_Read), .mem_size(mem_size), .fault(fault)
    );

    always #5 clk = ~clk;

    // One expected cycle: strb = {Reg_Write, IR_Write, PC_Write, Mem_Write, Mem_Read}.
    typedef struct {
        logic [4:0] strb;
        logic       flt;
        logic       rdy;
        logic [1:0] wds;
        logic [1:0] pcs;
        logic       c_alu;
        logic [3:0] aop;
        logic       rs2;
        logic       c_a;
        logic       alua;
        logic       c_ms;
        logic [2:0] ms;
    } rec_t;

    rec_t       tr[$];
    int         checks = 0;
    int         fails = 0;
    string      tag;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [6:0] cur_f7;
    logic       cur_z, cur_lt;
    bit         trap_after, trapped, hold_trap;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] outvec();
        return 32'({ALU_OP, rs2_imm_s, alu_a_s, w_data_s, pc_s, Reg_Write, IR_Write,
                    PC_Write, Mem_Write, Mem_Read, mem_size, fault});
    endfunction

    function automatic logic [31:0] strbvec();
        return 32'({Reg_Write, IR_Write, PC_Write, Mem_Write, Mem_Read, fault});
    endfunction

    function automatic rec_t blank();
        rec_t r;
        r.strb = '0;  r.flt = 1'b0; r.rdy = 1'($urandom_range(0, 1));
        r.wds = '0;   r.pcs = '0;   r.c_alu = 1'b0; r.aop = '0; r.rs2 = 1'b0;
        r.c_a = 1'b0; r.alua = 1'b0; r.c_ms = 1'b0; r.ms = '0;
        return r;
    endfunction

    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z, input logic lt, input int w);
        rec_t r;
        int   nm;
        bit   is_load, legal, taken;
        tr.delete();
        trap_after = 0;
        trapped = 0;
        cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z; cur_lt = lt;
        r = blank(); r.strb = 5'b01100; tr.push_back(r);
        r = blank(); tr.push_back(r);
        case (op)
            7'b0110011, 7'b0010011: begin
                r = blank(); r.c_alu = 1'b1;
                r.rs2 = (op == 7'b0010011);
                r.aop = (op == 7'b0110011) ? {f7[5], f3} : {(f3 == 3'b101) & f7[5], f3};
                tr.push_back(r);
                r.strb = 5'b10000; r.wds = 2'b00; tr.push_back(r);
            end
            7'b0110111: begin
                r = blank(); r.strb = 5'b10000; r.wds = 2'b01; tr.push_back(r);
            end
            7'b0010111: begin
                r = blank(); r.c_alu = 1'b1; r.aop = 4'b0000; r.rs2 = 1'b1;
                r.c_a = 1'b1; r.alua = 1'b1;
                tr.push_back(r);
                r.strb = 5'b10000; r.wds = 2'b00; tr.push_back(r);
            end
            7'b0000011, 7'b0100011: begin
                is_load = (op == 7'b0000011);
                legal = is_load ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                                : (f3 inside {3'd0, 3'd1, 3'd2});
                if (!legal) begin
                    trap_after = 1;
                end else begin
                    r = blank(); r.c_alu = 1'b1; r.aop = 4'b0000; r.rs2 = 1'b1;
                    r.c_a = 1'b1; r.alua = 1'b0; r.c_ms = 1'b1; r.ms = f3;
                    tr.push_back(r);
                    nm = (w > TO) ? TO + 1 : w + 1;
                    for (int k = 0; k < nm; k++) begin
                        r = blank(); r.strb = is_load ? 5'b00001 : 5'b00010;
                        r.c_ms = 1'b1; r.ms = f3; r.rdy = (k == w);
                        tr.push_back(r);
                    end
                    if (w > TO) begin
                        r = blank(); r.flt = 1'b1; tr.push_back(r);
                        trapped = 1;
                    end else if (is_load) begin
                        r = blank(); r.strb = 5'b10000; r.wds = 2'b10; r.c_ms = 1'b1; r.ms = f3;
                        tr.push_back(r);
                    end
                end
            end
`ifdef CU_BRANCH_JUMP_EN
            7'b1100011: begin
                if (f3 inside {3'b010, 3'b011}) begin
                    trap_after = 1;
                end else begin
                    r = blank(); r.c_alu = 1'b1; r.rs2 = 1'b0;
                    case (f3)
                        3'd0, 3'd1: r.aop = 4'b1000;
                        3'd4, 3'd5: r.aop = 4'b0010;
                        default:    r.aop = 4'b0011;
                    endcase
                    tr.push_back(r);
                    case (f3)
                        3'd0:       taken = z;
                        3'd1:       taken = !z;
                        3'd4, 3'd6: taken = lt;
                        default:    taken = !lt;
                    endcase
                    r = blank();
                    if (taken) begin r.strb = 5'b00100; r.pcs = 2'b01; end
                    tr.push_back(r);
                end
            end
            7'b1101111: begin
                r = blank(); r.strb = 5'b10100; r.wds = 2'b11; r.pcs = 2'b01; tr.push_back(r);
            end
            7'b1100111: begin
                if (f3 != 3'b000) begin
                    trap_after = 1;
                end else begin
                    r = blank(); r.c_alu = 1'b1; r.aop = 4'b0000; r.rs2 = 1'b1; tr.push_back(r);
                    r = blank(); r.strb = 5'b10100; r.wds = 2'b11; r.pcs = 2'b10; tr.push_back(r);
                end
            end
`endif
            default: trap_after = 1;
        endcase
        if (trap_after) trapped = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk({tag, ".rst_async"}, outvec(), 32'd0);
        @(negedge clk);
        chk({tag, ".rst_hold"}, outvec(), 32'd0);
        rst_n = 1'b1;
    endtask

    // Reset asserted mid-cycle: everything must clear without waiting for an edge.
    task automatic areset();
        @(posedge clk);
        #3 mem_ready = 1'b0;
        rst_n = 1'b0;
        #1 chk({tag, ".areset"}, outvec(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run();
        bit found;
        for (int i = 0; i < tr.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                opcode = cur_op; funct3 = cur_f3; funct7 = cur_f7; zero = cur_z; alu_lt = cur_lt;
            end
            mem_ready = tr[i].rdy;
            @(negedge clk);
            chk($sformatf("%s.c%0d.strb", tag, i), strbvec(), 32'({tr[i].strb, tr[i].flt}));
            if (tr[i].strb[4]) chk($sformatf("%s.c%0d.wds", tag, i), 32'(w_data_s), 32'(tr[i].wds));
            if (tr[i].strb[2]) chk($sformatf("%s.c%0d.pcs", tag, i), 32'(pc_s), 32'(tr[i].pcs));
            if (tr[i].c_alu)
                chk($sformatf("%s.c%0d.alu", tag, i), 32'({ALU_OP, rs2_imm_s}),
                    32'({2'b00, tr[i].aop, tr[i].rs2}));
            if (tr[i].c_a) chk($sformatf("%s.c%0d.alua", tag, i), 32'(alu_a_s), 32'(tr[i].alua));
            if (tr[i].c_ms) chk($sformatf("%s.c%0d.msize", tag, i), 32'(mem_size), 32'(tr[i].ms));
        end
        if (trap_after) begin
            found = 0;
            for (int k = 0; k < 4 && !found; k++) begin
                @(posedge clk);
                #1 mem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk({tag, ".trap_nostrb"}, 32'({Reg_Write, IR_Write, PC_Write, Mem_Write, Mem_Read}), 32'd0);
                found = (fault === 1'b1);
            end
            chk({tag, ".trap_reached"}, 32'(found), 32'd1);
        end
        if (trapped) begin
            repeat (2) begin
                @(negedge clk);
                chk({tag, ".trap_sticky"}, strbvec(), 32'd1);
            end
            if (!hold_trap) do_reset();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [6:0] op;
        hold_trap = 0;
        tag = "init";
        do_reset();

        tag = "add";
        build(7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0, 0); run();
        tag = "sub";
        build(7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0, 0); run();
        tag = "srai";
        build(7'b0010011, 3'b101, 7'b0100000, 1'b0, 1'b0, 0); run();
        tag = "addi_f7";
        build(7'b0010011, 3'b000, 7'b0100000, 1'b0, 1'b0, 0); run();
        tag = "lui";
        build(7'b0110111, 3'b010, 7'b0000000, 1'b0, 1'b0, 0); run();
        tag = "auipc";
        build(7'b0010111, 3'b000, 7'b0000000, 1'b0, 1'b0, 0); run();
        tag = "lb_w3";
        build(7'b0000011, 3'b000, 7'b0000000, 1'b0, 1'b0, 3); run();
        tag = "lhu_w4_limit";
        build(7'b0000011, 3'b101, 7'b0000000, 1'b0, 1'b0, TO); run();
        tag = "sw_w0";
        build(7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0, 0); run();
`ifdef CU_BRANCH_JUMP_EN
        tag = "beq_taken";
        build(7'b1100011, 3'b000, 7'b0000000, 1'b1, 1'b0, 0); run();
        tag = "beq_not";
        build(7'b1100011, 3'b000, 7'b0000000, 1'b0, 1'b0, 0); run();
        tag = "bgeu";
        build(7'b1100011, 3'b111, 7'b0000000, 1'b0, 1'b0, 0); run();
        tag = "jalr";
        build(7'b1100111, 3'b000, 7'b0000000, 1'b0, 1'b0, 0); run();
        tag = "jalr_bad";
        build(7'b1100111, 3'b001, 7'b0000000, 1'b0, 1'b0, 0); run();
`endif
        tag = "jal";
        build(7'b1101111, 3'b000, 7'b0000000, 1'b0, 1'b0, 0); run();
        tag = "fence";
        build(7'b0001111, 3'b000, 7'b0000000, 1'b0, 1'b0, 0); run();
        tag = "ld_bad_f3";
        build(7'b0000011, 3'b011, 7'b0000000, 1'b0, 1'b0, 0); run();

        tag = "sw_timeout";
        hold_trap = 1;
        build(7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0, TO + 1); run();
        areset();
        hold_trap = 0;

        tag = "lw_midreset";
        build(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0, TO);
        while (tr.size() > 5) tr.delete(tr.size() - 1);
        run();
        areset();

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 10))
                0, 9:    op = 7'b0110011;
                1:       op = 7'b0010011;
                2:       op = 7'b0110111;
                3:       op = 7'b0010111;
                4:       op = 7'b0000011;
                5:       op = 7'b0100011;
                6:       op = 7'b1100011;
                7:       op = 7'b1101111;
                8:       op = 7'b1100111;
                default: op = 7'($urandom);
            endcase
            tag = $sformatf("rnd%0d", n);
            build(op, 3'($urandom_range(0, 7)), 7'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, TO + 1));
            run();
        end

        tag = "final_add";
        build(7'b0110011, 3'b111, 7'b0000000, 1'b0, 1'b0, 0); run();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
